// File: rtl/decode_pipe.sv
// RV32 subset decoder (R-type, OP-IMM, LW, SW, LUI) with one registered output stage.
// Latency: 1 cycle from accepted instruction to out_valid; one bubble on load-use.
// Backpressure: bundle held while out_valid & !out_ready; in_ready drops on flush/hazard/full.
module decode_pipe #(
  parameter int XLEN           = 32,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     inst_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] imm_o,
  output logic [3:0]      alu_op_o,
  output logic            alu_src_o,
  output logic            reg_we_o,
  output logic            mem_re_o,
  output logic            mem_we_o,
  output logic            mem_to_reg_o,
  output logic            illegal_o
);

  localparam logic [3:0] ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, ALU_AND = 4'b0000,
                         ALU_OR  = 4'b0001, ALU_XOR = 4'b0011, ALU_SLL = 4'b0100,
                         ALU_SRL = 4'b0101, ALU_SRA = 4'b0111, ALU_SLT = 4'b1000,
                         ALU_SLTU = 4'b1001, ALU_PASSB = 4'b1010;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1_f, rs2_f, rd_f;

  assign opcode = inst_i[6:0];
  assign rd_f   = inst_i[11:7];
  assign funct3 = inst_i[14:12];
  assign rs1_f  = inst_i[19:15];
  assign rs2_f  = inst_i[24:20];
  assign funct7 = inst_i[31:25];

  function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  f3_op = ALU_SLL;
      3'b010:  f3_op = ALU_SLT;
      3'b011:  f3_op = ALU_SLTU;
      3'b100:  f3_op = ALU_XOR;
      3'b101:  f3_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f3_op = ALU_OR;
      default: f3_op = ALU_AND;
    endcase
  endfunction

  // Immediates built at 64 bits and truncated so both XLEN values share one path.
  logic [63:0] imm_i64, imm_s64, imm_u64;
  assign imm_i64 = {{52{inst_i[31]}}, inst_i[31:20]};
  assign imm_s64 = {{52{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_u64 = {{32{inst_i[31]}}, inst_i[31:12], 12'b0};

  logic [3:0]  d_op;
  logic [63:0] d_imm;
  logic        d_src, d_we, d_re, d_mw, d_m2r, d_ill, use_rs1, use_rs2, use_rd, is_load;

  always_comb begin
    d_op = ALU_ADD; d_imm = '0; d_src = 1'b0; d_we = 1'b0; d_re = 1'b0; d_mw = 1'b0;
    d_m2r = 1'b0; d_ill = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; use_rd = 1'b0; is_load = 1'b0;
    case (opcode)
      7'b0110011: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; d_we = 1'b1;
        d_op  = f3_op(funct3, funct7[5]);
        d_ill = !(funct7 == 7'b0000000 ||
                  (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      7'b0010011: begin
        use_rs1 = 1'b1; use_rd = 1'b1; d_we = 1'b1; d_src = 1'b1; d_imm = imm_i64;
        d_op = f3_op(funct3, (funct3 == 3'b101) && inst_i[30]);
        if (funct3 == 3'b001)
          d_ill = (funct7 != 7'b0000000);
        else if (funct3 == 3'b101)
          d_ill = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      7'b0000011: begin
        use_rs1 = 1'b1; use_rd = 1'b1; d_we = 1'b1; d_src = 1'b1; d_imm = imm_i64;
        d_re = 1'b1; d_m2r = 1'b1; is_load = 1'b1;
        d_ill = (funct3 != 3'b010);
      end
      7'b0100011: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; d_src = 1'b1; d_imm = imm_s64; d_mw = 1'b1;
        d_ill = (funct3 != 3'b010);
      end
      7'b0110111: begin
        use_rd = 1'b1; d_we = 1'b1; d_src = 1'b1; d_imm = imm_u64; d_op = ALU_PASSB;
      end
      default: d_ill = 1'b1;
    endcase
    // Illegal encodings travel downstream as an inert bundle with only illegal set.
    if (d_ill) begin
      d_op = 4'b0000; d_imm = '0; d_src = 1'b0; d_we = 1'b0; d_re = 1'b0; d_mw = 1'b0;
      d_m2r = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; use_rd = 1'b0; is_load = 1'b0;
    end
  end

  logic       ld_pend;
  logic [4:0] ld_rd;
  logic       hazard, slot_free, xfer;

  assign hazard = (LOAD_USE_STALL != 0) && ld_pend && in_valid &&
                  ((use_rs1 && rs1_f != 5'd0 && rs1_f == ld_rd) ||
                   (use_rs2 && rs2_f != 5'd0 && rs2_f == ld_rd));
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = !rst && !flush && !hazard && slot_free;
  assign xfer      = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0; ld_pend <= 1'b0; ld_rd <= '0;
      pc_o <= '0; rs1_o <= '0; rs2_o <= '0; rd_o <= '0; imm_o <= '0;
      alu_op_o <= '0; alu_src_o <= 1'b0; reg_we_o <= 1'b0; mem_re_o <= 1'b0;
      mem_we_o <= 1'b0; mem_to_reg_o <= 1'b0; illegal_o <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      ld_pend   <= 1'b0;
    end else if (xfer) begin
      out_valid    <= 1'b1;
      pc_o         <= pc_i;
      rs1_o        <= use_rs1 ? rs1_f : 5'd0;
      rs2_o        <= use_rs2 ? rs2_f : 5'd0;
      rd_o         <= use_rd ? rd_f : 5'd0;
      imm_o        <= d_imm[XLEN-1:0];
      alu_op_o     <= d_op;
      alu_src_o    <= d_src;
      reg_we_o     <= d_we && (rd_f != 5'd0);
      mem_re_o     <= d_re;
      mem_we_o     <= d_mw;
      mem_to_reg_o <= d_m2r;
      illegal_o    <= d_ill;
      ld_pend      <= is_load && (rd_f != 5'd0);
      if (is_load && rd_f != 5'd0) ld_rd <= rd_f;
    end else if (hazard && slot_free) begin
      out_valid <= 1'b0;
      ld_pend   <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width of pc_i, pc_o and imm_o (legal values 32 and 64).
REQ-002 Parameter LOAD_USE_STALL, default 1, enables load-use bubble insertion (0 = disabled).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  discard the held output and any pending hazard state.
REQ-006 in_valid  input  1  upstream has an instruction on pc_i/inst_i.
REQ-007 in_ready  output  1  decoder accepts the instruction this cycle.
REQ-008 pc_i  input  XLEN  instruction address.
REQ-009 inst_i  input  32  instruction word.
REQ-010 out_valid  output  1  decoded bundle valid.
REQ-011 out_ready  input  1  downstream accepts the bundle.
REQ-012 pc_o XLEN; rs1_o 5; rs2_o 5; rd_o 5; imm_o XLEN  output  registered decoded fields.
REQ-013 alu_op_o 4; alu_src_o 1; reg_we_o 1; mem_re_o 1; mem_we_o 1; mem_to_reg_o 1; illegal_o 1  output  registered control signals.

Function
REQ-014 Single output register stage: a transfer occurs when in_valid & in_ready, and the bundle is registered on that edge; latency is 1 cycle.
REQ-015 in_ready = !flush & !hazard & (!out_valid | out_ready); a bundle is held stable while out_valid & !out_ready.
REQ-016 out_valid clears on a downstream handshake with no new transfer.
REQ-017 R-type (opcode 0110011): alu_src=0, reg_we=1, reads rs1 and rs2; funct7/funct3 select ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 0011, SLL 0100, SRL 0101, SRA 0111, SLT 1000, SLTU 1001.
REQ-018 OP-IMM (0010011): alu_src=1, reg_we=1, reads rs1, I-immediate; ops as REQ-017. SUB is not valid. SRAI is selected by inst[30]=1.
REQ-019 LOAD LW (0000011, funct3 010): ADD, alu_src=1, reg_we=1, mem_re=1, mem_to_reg=1, I-immediate.
REQ-020 STORE SW (0100011, funct3 010): ADD, alu_src=1, mem_we=1, reg_we=0, reads rs1 and rs2, S-immediate.
REQ-021 LUI (0110111): alu_op 1010 (pass B), alu_src=1, reg_we=1, imm = {inst[31:12],12'b0}, reads no registers.
REQ-022 Immediates are sign-extended from inst[31] to XLEN.
REQ-023 Any other encoding, including a non-11 value in opcode[1:0]: illegal_o=1, and reg_we, mem_re and mem_we are all 0. The bundle is still passed downstream.
REQ-024 reg_we_o is forced to 0 when rd=0.
REQ-025 Hazard tracker state: ld_pend (1 bit) and ld_rd (5 bits). A transfer of a load with rd≠0 sets ld_pend and captures ld_rd. Any other transfer or inserted bubble clears ld_pend.
REQ-026 hazard = LOAD_USE_STALL & ld_pend & in_valid & (the incoming instruction reads rs1 or rs2 equal to ld_rd). Register x0 never hazards.
REQ-027 While hazard is asserted and the output slot is free (!out_valid | out_ready), the register loads a bubble (out_valid=0) and clears ld_pend. The dependent instruction is therefore accepted on the next cycle, giving exactly one bubble.
REQ-028 flush has priority over everything except rst. On flush, out_valid=0 and ld_pend=0 on the next edge, and no transfer occurs that cycle.

Reset
REQ-029 While rst=1 on an edge: out_valid=0, ld_pend=0, ld_rd=0, all registered outputs=0, and in_ready=0 during that cycle.
REQ-030 rst asserted mid-stall or while a bundle is held discards that bundle. The first transfer is possible on the cycle after rst deasserts.

Verification
REQ-031 0x002081B3 (add x3,x1,x2), out_ready=1 -> next cycle out_valid=1, rd=3, rs1=1, rs2=2, alu_op=0010, alu_src=0, reg_we=1.
REQ-032 0xFFF00293 (addi x5,x0,-1) -> imm_o=0xFFFFFFFF, alu_src=1, alu_op=0010; 0x0020A623 (sw x2,12(x1)) -> imm_o=12, mem_we=1, reg_we=0.
REQ-033 0x0080A303 (lw x6,8(x1)) followed by 0x000303B3 (add x7,x6,x0) -> in_ready=0 for one cycle and one out_valid=0 bubble, then the add is emitted. With LOAD_USE_STALL=0 there is no bubble.
REQ-034 out_ready held 0 for 3 cycles with a bundle held and in_valid=1 -> outputs stable, in_ready=0, and no instruction is lost or duplicated after release.
REQ-035 0x00000000 -> illegal_o=1, reg_we=0. flush asserted with a bundle held and ld_pend=1 -> out_valid=0 next cycle and the following dependent instruction is not stalled.
REQ-036 rst pulsed while a bundle is held -> out_valid=0 next cycle, and a fresh instruction is accepted once rst is low.
